// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter: FSM state
// encoding and the master identifiers used for ownership and round-robin.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb2.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// on a tie the master that was not granted last time wins.
module arb2_rr
  import mem_bus_arbiter_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic grant_id,
  output logic grant_valid
);

  // Pick the winner from the two request valids and the previous grant.
  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    if (ifu_valid && lsu_valid) begin
      grant_id = ~last_grant;
    end else if (lsu_valid) begin
      grant_id = M_LSU;
    end else begin
      grant_id = M_IFU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU read-only, LSU load/store) to one memory port arbiter.
// One transaction in flight: IDLE arbitrates and latches the request,
// SEND presents it to memory, WAIT passes the response back to the owner.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  logic              owner_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              grant_id_s;
  logic              grant_valid_s;
  logic              accept_s;
  logic              owner_resp_ready_s;

  arb2_rr u_arb (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_grant  (last_grant_r),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  assign accept_s           = (state_r == ST_IDLE) && grant_valid_s;
  assign owner_resp_ready_s = (owner_r == M_LSU) ? lsu_resp_ready : ifu_resp_ready;

  assign mem_req_addr  = addr_r;
  assign mem_req_wdata = wdata_r;
  assign mem_req_wmask = wmask_r;

  // FSM state register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept -> send until memory takes it -> wait for response.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) state_nxt_s = ST_SEND;
        else               state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (mem_req_ready) state_nxt_s = ST_WAIT;
        else               state_nxt_s = ST_SEND;
      end
      ST_WAIT: begin
        if (mem_resp_valid && owner_resp_ready_s) state_nxt_s = ST_IDLE;
        else                                      state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Latch the winning request and remember who owns the port and who won last.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r      <= M_IFU;
      last_grant_r <= M_IFU;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      wmask_r      <= {MASK_W{1'b0}};
    end else if (accept_s) begin
      owner_r      <= grant_id_s;
      last_grant_r <= grant_id_s;
      if (grant_id_s == M_LSU) begin
        addr_r  <= lsu_req_addr;
        wdata_r <= lsu_req_wdata;
        wmask_r <= lsu_req_wmask;
      end else begin
        // Fetches are always reads: no store data, empty byte mask.
        addr_r  <= ifu_req_addr;
        wdata_r <= {DATA_W{1'b0}};
        wmask_r <= {MASK_W{1'b0}};
      end
    end
  end

  // Handshake outputs per state; response path is a pass-through to the owner.
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_resp_rdata = {DATA_W{1'b0}};
    lsu_resp_rdata = {DATA_W{1'b0}};
    if (rst) begin
      // Keep every handshake quiet while reset is applied.
      mem_req_valid = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ifu_req_ready = grant_valid_s && (grant_id_s == M_IFU);
          lsu_req_ready = grant_valid_s && (grant_id_s == M_LSU);
        end
        ST_SEND: begin
          mem_req_valid = 1'b1;
        end
        ST_WAIT: begin
          if (owner_r == M_LSU) begin
            mem_resp_ready = lsu_resp_ready;
            lsu_resp_valid = mem_resp_valid;
            lsu_resp_rdata = mem_resp_rdata;
          end else begin
            mem_resp_ready = ifu_resp_ready;
            ifu_resp_valid = mem_resp_valid;
            ifu_resp_rdata = mem_resp_rdata;
          end
        end
        default: begin
          mem_req_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr, ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_wmask;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit model_last;           // master granted most recently (0 = IFU, 1 = LSU)

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    model_last = 1'b0;
  endtask

  // One complete transaction from an IDLE-cycle negedge back to the next IDLE.
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                     input logic [31:0] lwd, input logic [3:0] lwm, input logic [31:0] rd,
                     input int req_stall, input int resp_delay, input int bp,
                     input bit hold, output int acc);
    bit w, resp_on, owner_rr;
    logic [31:0] ea, ewd;
    logic [3:0]  ewm;
    ifu_req_valid = iv; lsu_req_valid = lv;
    ifu_req_addr = ia; lsu_req_addr = la; lsu_req_wdata = lwd; lsu_req_wmask = lwm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    w = (iv && lv) ? ~model_last : lv;
    if (w) begin ea = la; ewd = lwd; ewm = lwm; end
    else   begin ea = ia; ewd = 32'd0; ewm = 4'd0; end
    #1;
    chk("idle_ifu_req_ready", 32'(ifu_req_ready), 32'(!w));
    chk("idle_lsu_req_ready", 32'(lsu_req_ready), 32'(w));
    chk("idle_mem_req_valid", 32'(mem_req_valid), 32'd0);
    acc = cyc;
    model_last = w;
    tick;
    if (!hold) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    ifu_req_addr = $urandom; lsu_req_addr = $urandom;
    lsu_req_wdata = $urandom; lsu_req_wmask = 4'($urandom);
    for (int i = 0; i <= req_stall; i++) begin
      mem_req_ready  = (i == req_stall);
      mem_resp_valid = 1'($urandom_range(1, 0));
      mem_resp_rdata = $urandom;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      #1;
      chk("send_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("send_addr", mem_req_addr, ea);
      chk("send_wdata", mem_req_wdata, ewd);
      chk("send_wmask", 32'(mem_req_wmask), 32'(ewm));
      chk("send_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
      chk("send_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
      chk("send_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
      chk("send_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
      chk("send_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
      tick;
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < resp_delay + bp + 1; i++) begin
      resp_on  = (i >= resp_delay);
      owner_rr = (i >= resp_delay + bp);
      mem_resp_valid = resp_on;
      mem_resp_rdata = resp_on ? rd : $urandom;
      if (w) begin lsu_resp_ready = owner_rr; ifu_resp_ready = !owner_rr; end
      else   begin ifu_resp_ready = owner_rr; lsu_resp_ready = !owner_rr; end
      #1;
      chk("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("wait_mem_resp_ready", 32'(mem_resp_ready), 32'(owner_rr));
      chk("wait_ifu_resp_valid", 32'(ifu_resp_valid), 32'(!w && resp_on));
      chk("wait_lsu_resp_valid", 32'(lsu_resp_valid), 32'(w && resp_on));
      chk("wait_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
      chk("wait_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
      if (resp_on) chk("wait_rdata", w ? lsu_resp_rdata : ifu_resp_rdata, rd);
      tick;
    end
    mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, a3, sel;
    bit riv, rlv;
    rst = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_req_addr = 32'd0; lsu_req_addr = 32'd0; lsu_req_wdata = 32'd0; lsu_req_wmask = 4'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    model_last = 1'b0;
    @(negedge clk);
    tick;
    // Reset state: requests present but nothing handshakes.
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("rst_resp_valids", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("rst_latched", mem_req_addr | mem_req_wdata | 32'(mem_req_wmask), 32'd0);
    do_reset;

    // IFU fetch, memory answers after two cycles.
    txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 4'd0, 32'hDEAD_BEEF, 0, 2, 0, 1'b0, a0);
    // LSU store, memory stalls the request three cycles.
    txn(1'b0, 1'b1, 32'd0, 32'h8000_0010, 32'h1234_5678, 4'b0011, 32'h0, 3, 0, 0, 1'b0, a0);

    // Tie right after reset: LSU, IFU, LSU, IFU with 0-wait memory.
    do_reset;
    txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 32'hAAAA_0001, 4'b1111, 32'h1111_1111, 0, 0, 0, 1'b1, a0);
    txn(1'b1, 1'b1, 32'h0000_1004, 32'h0000_2004, 32'hAAAA_0002, 4'b0000, 32'h2222_2222, 0, 0, 0, 1'b1, a1);
    txn(1'b1, 1'b1, 32'h0000_1008, 32'h0000_2008, 32'hAAAA_0003, 4'b0101, 32'h3333_3333, 0, 0, 0, 1'b1, a2);
    txn(1'b1, 1'b1, 32'h0000_100C, 32'h0000_200C, 32'hAAAA_0004, 4'b0000, 32'h4444_4444, 0, 0, 0, 1'b0, a3);
    chk("rr_gap", 32'(a1 - a0), 32'd3);
    chk("rr_gap2", 32'(a3 - a2), 32'd3);

    // LSU load with four cycles of response backpressure.
    txn(1'b0, 1'b1, 32'd0, 32'h8000_0020, 32'd0, 4'd0, 32'hCAFE_F00D, 0, 0, 4, 1'b0, a0);

    // Reset while in SEND: drops the transaction and clears round-robin history.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0030; lsu_req_wmask = 4'b1000;
    tick;
    lsu_req_valid = 1'b0;
    #1;
    chk("pre_rst_send_valid", 32'(mem_req_valid), 32'd1);
    rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("in_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("in_rst_req_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
    tick;
    rst = 1'b0;
    model_last = 1'b0;
    #1;
    chk("post_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    txn(1'b1, 1'b1, 32'h0000_3000, 32'h0000_4000, 32'h5555_5555, 4'b0110, 32'h6666_6666, 0, 0, 0, 1'b0, a0);

    // Back-to-back IFU fetches with 0-wait memory: accepts exactly 3 cycles apart.
    txn(1'b1, 1'b0, 32'h8000_0100, 32'd0, 32'd0, 4'd0, 32'h0101_0101, 0, 0, 0, 1'b1, a0);
    txn(1'b1, 1'b0, 32'h8000_0104, 32'd0, 32'd0, 4'd0, 32'h0202_0202, 0, 0, 0, 1'b1, a1);
    txn(1'b1, 1'b0, 32'h8000_0108, 32'd0, 32'd0, 4'd0, 32'h0303_0303, 0, 0, 0, 1'b0, a2);
    chk("b2b_gap1", 32'(a1 - a0), 32'd3);
    chk("b2b_gap2", 32'(a2 - a1), 32'd3);

    // Randomized mix of requesters, stalls, latencies and backpressure.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(2, 0);
      riv = (sel != 1);
      rlv = (sel != 0);
      txn(riv, rlv, $urandom, $urandom, $urandom, 4'($urandom), $urandom,
          $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0), 1'b0, a0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
